dram_ctrl: RTL and testbench
============================

DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, data RAM size in 32-bit words, power of two.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request accept to dram_data_ok, legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port dram_req  input  1  request valid from EX stage.
REQ-006 SHALL have port dram_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port dram_addr  input  32  byte address; bits [log2(DEPTH)+1:2] index the word.
REQ-008 SHALL have port dram_wdata  input  32  store data, already lane-aligned.
REQ-009 SHALL have port dram_wstrb  input  4  store byte enables.
REQ-010 SHALL have port dram_addr_ok  output  1  request accepted this cycle.
REQ-011 SHALL have port dram_flush  input  1  cancel any pending load response.
REQ-012 SHALL have port dram_resp_ready  input  1  MEM stage consumes response this cycle.
REQ-013 SHALL have port dram_data_ok  output  1  response valid.
REQ-014 SHALL have port dram_rdata  output  32  full load word; MEM stage does byte/half select and extension.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP; one transaction outstanding at most.
REQ-016 SHALL drive dram_addr_ok = (state==IDLE) & ~dram_flush, combinationally; acceptance = dram_req & dram_addr_ok.
REQ-017 SHALL commit stores to RAM in the accept cycle, per byte under dram_wstrb; wstrb=0 writes nothing.
REQ-018 SHALL, on load accept in cycle T, read the RAM and assert dram_data_ok first in cycle T+LATENCY with the word at that address.
REQ-019 SHALL go IDLE->BUSY on accepted load when LATENCY>1, IDLE->RESP when LATENCY=1; BUSY counts down a 4-bit counter loaded with LATENCY-1, ->RESP at zero.
REQ-020 SHALL hold dram_data_ok and dram_rdata stable in RESP until dram_resp_ready=1, then ->IDLE next cycle.
REQ-021 SHALL ignore upper address bits (wrap modulo DEPTH) and bits [1:0]; no misalignment fault.
REQ-022 SHALL, on dram_flush in RESP, deassert dram_data_ok that cycle and go IDLE next cycle.
REQ-023 SHALL, on dram_flush in BUSY, set a drop flag; the counter completes, no dram_data_ok is produced, FSM returns IDLE.
REQ-024 SHALL not undo a store already committed when dram_flush arrives; flush with dram_req in IDLE rejects the request.
REQ-025 SHALL return the newest data for a load issued the cycle after a store to the same word.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, dram_data_ok=0, dram_addr_ok=0, dram_rdata=0, counter=0, drop flag=0.
REQ-027 SHALL abandon any in-flight load on reset mid-operation, with no response after rst deasserts; RAM contents are not reset.

Configuration
REQ-028 SHALL honour macro DRAM_WRITE_RESP_EN: defined -> stores traverse BUSY/RESP like loads and return dram_data_ok with dram_rdata=0 after LATENCY cycles.
REQ-029 SHALL, without DRAM_WRITE_RESP_EN, keep FSM in IDLE on stores (no response), allowing one accepted store per cycle.

Structure
REQ-030 SHALL place the FSM state enum and the LATENCY counter width constant (4) in shared package dram_pkg.
REQ-031 SHALL instantiate sub-module dram_sram: single-port, synchronous-read, byte-write-enable 32-bit RAM of DEPTH words.

Verification
REQ-032 SHALL cover: LATENCY=1, store 0xDEADBEEF wstrb=0xF to 0x100, then load 0x100 -> data_ok one cycle after accept, rdata=0xDEADBEEF.
REQ-033 SHALL cover: LATENCY=3, load with resp_ready held 0 for 5 cycles -> data_ok at T+3, held with stable rdata until resp_ready, addr_ok=0 throughout.
REQ-034 SHALL cover: store 0x000000AB wstrb=0x2 over word 0x11223344 -> reload returns 0x1122AB44 (wdata pre-aligned as 0x0000AB00).
REQ-035 SHALL cover: LATENCY=4, flush at T+2 -> no data_ok, addr_ok=1 by T+5; preceding store data persists.
REQ-036 SHALL cover: rst pulsed during BUSY -> data_ok never asserts; next load returns correct data.
REQ-037 SHALL cover: DEPTH=1024, access 0x1000 aliases word 0; both DRAM_WRITE_RESP_EN builds checked for store response presence/absence.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types for the data-RAM controller.
// Holds the FSM state encoding and the latency counter width.
package dram_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dram_sram.sv
// Single-port data RAM: synchronous read, per-byte write enables.
// The read register only moves when en is high, so it holds between accesses.
module dram_sram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// Data-RAM controller between EX (request) and MEM (response) stages.
// Optional macro DRAM_WRITE_RESP_EN: stores also produce a response.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dram_req,
    input  logic        dram_write,
    input  logic [31:0] dram_addr,
    input  logic [31:0] dram_wdata,
    input  logic [3:0]  dram_wstrb,
    output logic        dram_addr_ok,
    input  logic        dram_flush,
    input  logic        dram_resp_ready,
    output logic        dram_data_ok,
    output logic [31:0] dram_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             wr_q, wr_d;
    logic             accept;
    logic             track;
    logic [31:0]      sram_q;
    logic             unused_addr;

    assign unused_addr = ^{dram_addr[31:AW+2], dram_addr[1:0]};

    assign dram_addr_ok = (state_q == IDLE) & ~dram_flush & ~rst;
    assign accept       = dram_req & dram_addr_ok;

`ifdef DRAM_WRITE_RESP_EN
    assign track = accept;
`else
    assign track = accept & ~dram_write;
`endif

    // Stores commit in the accept cycle; the read side is only used by loads.
    dram_sram #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (accept),
        .we    (dram_write ? dram_wstrb : 4'b0000),
        .addr  (dram_addr[AW+1:2]),
        .wdata (dram_wdata),
        .rdata (sram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        wr_d    = wr_q;
        unique case (state_q)
            IDLE: begin
                if (track) begin
                    wr_d   = dram_write;
                    drop_d = 1'b0;
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (dram_flush) begin
                    drop_d = 1'b1;
                end
                // A flushed access still runs its count before freeing up.
                if (cnt_q <= 1) begin
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    state_d = (drop_q | dram_flush) ? IDLE : RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (dram_flush | dram_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dram_data_ok = (state_q == RESP) & ~dram_flush & ~rst;
    assign dram_rdata   = (state_q == RESP && !wr_q && !rst) ? sram_q : '0;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: three instances (LATENCY 1/3/4) share stimulus.
// Expected timing comes from a per-transaction rule model; data from a word array.
module tb_dram_ctrl;

    localparam int N = 3;
    localparam int LAT [N] = '{1, 3, 4};
`ifdef DRAM_WRITE_RESP_EN
    localparam bit WR_RESP = 1'b1;
`else
    localparam bit WR_RESP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req, write, flush, rready;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [N-1:0] aok, dok;
    logic [31:0] rdata [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dram_ctrl #(
            .DEPTH   (1024),
            .LATENCY (LAT[g])
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .dram_req        (req),
            .dram_write      (write),
            .dram_addr       (addr),
            .dram_wdata      (wdata),
            .dram_wstrb      (wstrb),
            .dram_addr_ok    (aok[g]),
            .dram_flush      (flush),
            .dram_resp_ready (rready),
            .dram_data_ok    (dok[g]),
            .dram_rdata      (rdata[g])
        );
    end

    int total  = 0;
    int passed = 0;
    int failed = 0;
    logic [31:0] mem [1024];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] ws);
        mem[a[11:2]] = merge(mem[a[11:2]], wd, ws);
    endtask

    // f: flush cycle after accept (0 none); rdy: first ready cycle;
    // rk: reset cycle (0 none); pre: store to same word the cycle before.
    task automatic run_txn(input string nm, input bit wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input int f, input int rdy,
                           input int rk, input bit pre);
        logic [31:0] exp;
        bit respond, eok, eaok;
        int cons, fin;
        @(posedge clk); #1;
        if (pre) begin
            req = 1; write = 1; addr = a; wdata = wd; wstrb = ws;
            model_store(a, wd, ws);
            @(negedge clk);
            for (int i = 0; i < N; i++)
                check($sformatf("%s pre_aok L%0d", nm, LAT[i]), aok[i], 1);
            @(posedge clk); #1;
            wdata = ~wd;
        end
        req = 1; write = wr; addr = a; wstrb = ws;
        if (!pre) wdata = wd;
        if (wr) model_store(a, wd, ws);
        exp = wr ? 32'h0 : mem[a[11:2]];
        respond = wr ? WR_RESP : 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            check($sformatf("%s acc_aok L%0d", nm, LAT[i]), aok[i], 1);
        @(posedge clk); #1;
        req = 0; write = 0;
        for (int k = 1; k <= 12; k++) begin
            flush  = (k == f);
            rready = (k >= rdy);
            rst    = (k == rk);
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                cons = (rdy > LAT[i]) ? rdy : LAT[i];
                if (rk > 0) begin
                    eok = 0; eaok = (k > rk);
                end else if (!respond) begin
                    eok = 0; eaok = (k != f);
                end else begin
                    if (f > 0 && f < LAT[i]) begin
                        eok = 0; fin = LAT[i] - 1;
                    end else if (f > 0 && f <= cons) begin
                        eok = (k >= LAT[i]) && (k < f); fin = f;
                    end else begin
                        eok = (k >= LAT[i]) && (k <= cons); fin = cons;
                    end
                    eaok = (k > fin) && (k != f);
                end
                check($sformatf("%s dok L%0d k%0d", nm, LAT[i], k), dok[i], eok);
                check($sformatf("%s aok L%0d k%0d", nm, LAT[i], k), aok[i], eaok);
                if (eok)
                    check($sformatf("%s rdata L%0d k%0d", nm, LAT[i], k),
                          rdata[i], exp);
            end
            @(posedge clk); #1;
        end
        flush = 0; rready = 0; rst = 0;
    endtask

    initial begin
        logic [31:0] a, d;
        rst = 1; req = 0; write = 0; flush = 0; rready = 0;
        addr = 0; wdata = 0; wstrb = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst aok L%0d", LAT[i]), aok[i], 0);
            check($sformatf("rst dok L%0d", LAT[i]), dok[i], 0);
            check($sformatf("rst rdata L%0d", LAT[i]), rdata[i], 0);
        end
        @(posedge clk); #1;
        rst = 0;

        run_txn("st_beef", 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        run_txn("ld_beef", 0, 32'h100, 0, 0, 0, 1, 0, 0);
        run_txn("ld_hold", 0, 32'h100, 0, 0, 0, 8, 0, 0);

        run_txn("st_base", 1, 32'h200, 32'h11223344, 4'hF, 0, 0, 0, 0);
        run_txn("st_lane", 1, 32'h200, 32'h0000AB00, 4'h2, 0, 0, 0, 0);
        run_txn("st_zero", 1, 32'h200, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0);
        run_txn("ld_lane", 0, 32'h200, 0, 0, 0, 2, 0, 0);
        check("lane model", mem[128], 32'h1122AB44);

        run_txn("st_300", 1, 32'h300, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
        run_txn("ld_flbusy", 0, 32'h300, 0, 0, 2, 0, 0, 0);
        run_txn("ld_after", 0, 32'h300, 0, 0, 0, 0, 0, 0);
        run_txn("ld_flresp", 0, 32'h300, 0, 0, 6, 9, 0, 0);
        run_txn("ld_rst", 0, 32'h300, 0, 0, 0, 0, 1, 0);
        run_txn("ld_postrst", 0, 32'h300, 0, 0, 0, 0, 0, 0);

        // Flushed request in IDLE must not commit.
        @(posedge clk); #1;
        req = 1; write = 1; addr = 32'h100; wdata = 32'h12345678;
        wstrb = 4'hF; flush = 1;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            check($sformatf("flush_rej aok L%0d", LAT[i]), aok[i], 0);
        @(posedge clk); #1;
        req = 0; write = 0; flush = 0;
        run_txn("ld_norej", 0, 32'h100, 0, 0, 0, 0, 0, 0);

        run_txn("st_alias", 1, 32'h1000, 32'hA5A55A5A, 4'hF, 0, 0, 0, 0);
        run_txn("ld_alias0", 0, 32'h0, 0, 0, 0, 0, 0, 0);
        run_txn("ld_alias3", 0, 32'h1003, 0, 0, 0, 3, 0, 0);
        if (!WR_RESP)
            run_txn("st_then_ld", 0, 32'h204, 32'h0BADCAFE, 4'hF, 0, 0, 0, 1);

        for (int w = 0; w < 64; w++)
            run_txn("init", 1, 32'(w * 4), $urandom, 4'hF, 0, 0, 0, 0);
        for (int it = 0; it < 16; it++) begin
            a = {$urandom_range(0, 3), 10'h0, 2'b0} + 32'($urandom_range(0, 63) * 4)
                + 32'($urandom_range(0, 3));
            d = $urandom;
            run_txn("rnd_st", 1, a << 2 >> 2, d, 4'($urandom_range(0, 15)),
                    0, 0, 0, 0);
            a = 32'($urandom_range(0, 63) * 4) + {$urandom_range(0, 3), 12'h0};
            run_txn("rnd_ld", 0, a, 0, 0,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0,
                    $urandom_range(0, 6), 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
